// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the shared combinational ALU and the
// response consumer. The arbiter takes the slave side and the environment takes the master side.
interface alu_arbiter_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            req0_valid;
    logic            req0_ready;
    logic [3:0]      req0_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic [3:0]      req1_op;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] alu_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_dbz;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_op, alu_in1, alu_in2,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_data, rsp_dbz,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_op, alu_in1, alu_in2,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_dbz,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving two requesters turns on one shared combinational ALU.
// It holds each operation for its execute latency and substitutes a divide-by-zero result.
module alu_arbiter #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_grant;
    logic [3:0]      w_sel_op;
    logic [XLEN-1:0] w_sel_a;
    logic [XLEN-1:0] w_sel_b;
    logic            w_done;
    logic            w_dbz;

    logic            r_last_id;
    logic            r_id;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [3:0]      r_cnt;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_dbz;

    // Counter preload: the EXEC state spends (load + 1) cycles on the operation.
    function automatic logic [3:0] exec_load(input logic [3:0] op);
        logic [3:0] v;
        case (op)
            OP_MUL:  v = MUL_LOAD;
            OP_DIV:  v = DIV_LOAD;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode; on a tie the requester not served last wins
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    if (r_last_id) begin
                        w_grant0 = 1'b1;
                    end else begin
                        w_grant1 = 1'b1;
                    end
                end else if (bus.req0_valid) begin
                    w_grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b0;
                end
                if (w_grant0 || w_grant1) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_grant  = w_grant0 | w_grant1;
    assign w_sel_op = w_grant1 ? bus.req1_op : bus.req0_op;
    assign w_sel_a  = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_grant1 ? bus.req1_b  : bus.req0_b;
    assign w_done   = (r_state == S_EXEC) && (r_cnt == 4'd0);
    assign w_dbz    = (r_op == OP_DIV) && (r_b == {XLEN{1'b0}});

    // Latch the granted request and run the execute-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_op      <= 4'd0;
            r_a       <= {XLEN{1'b0}};
            r_b       <= {XLEN{1'b0}};
            r_cnt     <= 4'd0;
        end else if (w_grant) begin
            r_last_id <= w_grant1;
            r_id      <= w_grant1;
            r_op      <= w_sel_op;
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_cnt     <= exec_load(w_sel_op);
        end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Response capture on the last EXEC cycle, held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= {XLEN{1'b0}};
            r_rsp_dbz   <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= w_dbz ? {XLEN{1'b1}} : bus.alu_result;
            r_rsp_dbz   <= w_dbz;
        end else if ((r_state == S_RESP) && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    // The ALU sees a quiet all-zero operation whenever nothing is executing
    assign bus.alu_op     = (r_state == S_EXEC) ? r_op : 4'b0000;
    assign bus.alu_in1    = (r_state == S_EXEC) ? r_a  : {XLEN{1'b0}};
    assign bus.alu_in2    = (r_state == S_EXEC) ? r_b  : {XLEN{1'b0}};
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_dbz    = r_rsp_dbz;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the shared port.
module tb_alu_arbiter;
    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_arbiter_if #(.XLEN(XLEN)) bus_if ();

    alu_arbiter #(.XLEN(XLEN), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; a divide by zero returns junk that the arbiter must discard
    always_comb begin
        case (bus_if.alu_op)
            4'b0001: bus_if.alu_result = bus_if.alu_in1 + bus_if.alu_in2;
            4'b0010: bus_if.alu_result = bus_if.alu_in1 - bus_if.alu_in2;
            4'b0011: bus_if.alu_result = bus_if.alu_in1 * bus_if.alu_in2;
            4'b1000: bus_if.alu_result = (bus_if.alu_in2 == 64'd0) ? 64'h0BAD_0BAD_0BAD_0BAD
                                                                   : bus_if.alu_in1 / bus_if.alu_in2;
            default: bus_if.alu_result = 64'd0;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int start, input int max, output int n);
        n = start;
        while (!bus_if.rsp_valid && n < max) begin
            cyc();
            n++;
        end
    endtask

    task automatic clear_reqs();
        bus_if.req0_valid = 1'b0; bus_if.req0_op = 4'd0; bus_if.req0_a = 64'd0; bus_if.req0_b = 64'd0;
        bus_if.req1_valid = 1'b0; bus_if.req1_op = 4'd0; bus_if.req1_a = 64'd0; bus_if.req1_b = 64'd0;
    endtask

    task automatic test_reset();
        clear_reqs();
        bus_if.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) cyc();
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h expected 0", bus_if.rsp_data); end
        n_checks++; if ({bus_if.rsp_id, bus_if.rsp_dbz} !== 2'b00) begin n_fail++; $display("FAIL reset_id_dbz: got %b expected 00", {bus_if.rsp_id, bus_if.rsp_dbz}); end
        n_checks++; if (bus_if.alu_op !== 4'd0 || bus_if.alu_in1 !== 64'd0) begin n_fail++; $display("FAIL reset_alu: got op %h in1 %0h expected 0", bus_if.alu_op, bus_if.alu_in1); end
        rst_n = 1'b1;
        cyc();
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_readys: got %b expected 00", {bus_if.req0_ready, bus_if.req1_ready}); end
    endtask

    task automatic test_add();
        int n;
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b0001; bus_if.req0_a = 64'd5; bus_if.req0_b = 64'd7;
        #1;
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL add_grant: got %b expected 10", {bus_if.req0_ready, bus_if.req1_ready}); end
        cyc();
        bus_if.req0_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.alu_op !== 4'b0001 || bus_if.alu_in1 !== 64'd5 || bus_if.alu_in2 !== 64'd7) begin n_fail++; $display("FAIL add_exec_drive: got op %h in1 %0d in2 %0d expected 1 5 7", bus_if.alu_op, bus_if.alu_in1, bus_if.alu_in2); end
        wait_rsp(1, 20, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", n); end
        n_checks++; if (bus_if.rsp_data !== 64'd12 || bus_if.rsp_id !== 1'b0 || bus_if.rsp_dbz !== 1'b0) begin n_fail++; $display("FAIL add_rsp: got data %0d id %b dbz %b expected 12 0 0", bus_if.rsp_data, bus_if.rsp_id, bus_if.rsp_dbz); end
        n_checks++; if (bus_if.alu_op !== 4'd0) begin n_fail++; $display("FAIL add_resp_alu_quiet: got %h expected 0", bus_if.alu_op); end
        cyc();
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_drop: got %b expected 0", bus_if.rsp_valid); end
    endtask

    task automatic test_contention();
        int n;
        logic [63:0] exp_d;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        bus_if.rsp_ready  = 1'b1;
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b0010; bus_if.req0_a = 64'd10; bus_if.req0_b = 64'd3;
        bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'b0011; bus_if.req1_a = 64'd6;  bus_if.req1_b = 64'd7;
        #1;
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rr_first: got %b expected 10", {bus_if.req0_ready, bus_if.req1_ready}); end
        cyc();
        bus_if.req0_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.req1_ready !== 1'b0) begin n_fail++; $display("FAIL exec_no_ready: got %b expected 0", bus_if.req1_ready); end
        cyc();
        n_checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 64'd7 || bus_if.rsp_id !== 1'b0) begin n_fail++; $display("FAIL sub_rsp: got v %b data %0d id %b expected 1 7 0", bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_id); end
        cyc();
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL rr_second: got %b expected 01", {bus_if.req0_ready, bus_if.req1_ready}); end
        cyc();
        bus_if.req1_valid = 1'b0;
        wait_rsp(1, 20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL mul_latency: got %0d expected 4", n); end
        n_checks++; if (bus_if.rsp_data !== 64'd42 || bus_if.rsp_id !== 1'b1 || bus_if.rsp_dbz !== 1'b0) begin n_fail++; $display("FAIL mul_rsp: got data %0d id %b dbz %b expected 42 1 0", bus_if.rsp_data, bus_if.rsp_id, bus_if.rsp_dbz); end
        cyc();
        // Sustained contention: ADD 1+1 on req0, ADD 2+2 on req1, grants alternate from req0
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b0001; bus_if.req0_a = 64'd1; bus_if.req0_b = 64'd1;
        bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'b0001; bus_if.req1_a = 64'd2; bus_if.req1_b = 64'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if ({bus_if.req0_ready, bus_if.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_alternate_%0d: got %b expected %b", k, {bus_if.req0_ready, bus_if.req1_ready}, ((k % 2 == 0) ? 2'b10 : 2'b01));
            end
            repeat (2) cyc();
            exp_d = (k % 2 == 0) ? 64'd2 : 64'd4;
            n_checks++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== exp_d) begin
                n_fail++; $display("FAIL rr_data_%0d: got v %b data %0d expected 1 %0d", k, bus_if.rsp_valid, bus_if.rsp_data, exp_d);
            end
            cyc();
        end
        clear_reqs();
        cyc();
    endtask

    task automatic test_div();
        int n;
        bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'b1000; bus_if.req1_a = 64'd100; bus_if.req1_b = 64'd0;
        #1;
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL div0_grant: got %b expected 01", {bus_if.req0_ready, bus_if.req1_ready}); end
        cyc();
        bus_if.req1_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.alu_op !== 4'b1000) begin n_fail++; $display("FAIL div0_alu_op: got %h expected 8", bus_if.alu_op); end
        wait_rsp(1, 30, n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL div0_latency: got %0d expected 9", n); end
        n_checks++; if (bus_if.rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || bus_if.rsp_dbz !== 1'b1 || bus_if.rsp_id !== 1'b1) begin n_fail++; $display("FAIL div0_rsp: got data %0h dbz %b id %b expected all-ones 1 1", bus_if.rsp_data, bus_if.rsp_dbz, bus_if.rsp_id); end
        cyc();
        bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'b1000; bus_if.req1_a = 64'd100; bus_if.req1_b = 64'd7;
        cyc();
        bus_if.req1_valid = 1'b0;
        wait_rsp(1, 30, n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL div_latency: got %0d expected 9", n); end
        n_checks++; if (bus_if.rsp_data !== 64'd14 || bus_if.rsp_dbz !== 1'b0) begin n_fail++; $display("FAIL div_rsp: got data %0d dbz %b expected 14 0", bus_if.rsp_data, bus_if.rsp_dbz); end
        cyc();
    endtask

    task automatic test_op15();
        int n;
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b1111; bus_if.req0_a = 64'd3; bus_if.req0_b = 64'd4;
        cyc();
        bus_if.req0_valid = 1'b0;
        wait_rsp(1, 20, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL op15_latency: got %0d expected 2", n); end
        n_checks++; if (bus_if.rsp_data !== 64'd0 || bus_if.rsp_dbz !== 1'b0) begin n_fail++; $display("FAIL op15_rsp: got data %0h dbz %b expected 0 0", bus_if.rsp_data, bus_if.rsp_dbz); end
        cyc();
    endtask

    task automatic test_backpressure();
        int n;
        bus_if.rsp_ready  = 1'b0;
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b0001; bus_if.req0_a = 64'd1; bus_if.req0_b = 64'd2;
        cyc();
        bus_if.req0_valid = 1'b0;
        wait_rsp(1, 20, n);
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b0001; bus_if.req0_a = 64'd8; bus_if.req0_b = 64'd8;
        bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'b0010; bus_if.req1_a = 64'd9; bus_if.req1_b = 64'd4;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 64'd3 || {bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin
                n_fail++; $display("FAIL hold_%0d: got v %b data %0d readys %b expected 1 3 00", k, bus_if.rsp_valid, bus_if.rsp_data, {bus_if.req0_ready, bus_if.req1_ready});
            end
            cyc();
        end
        bus_if.rsp_ready = 1'b1;
        cyc();
        #1;
        n_checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b01 || bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL after_accept_grant: got readys %b v %b expected 01 0", {bus_if.req0_ready, bus_if.req1_ready}, bus_if.rsp_valid); end
        cyc();
        clear_reqs();
        wait_rsp(1, 20, n);
        n_checks++; if (bus_if.rsp_data !== 64'd5 || bus_if.rsp_id !== 1'b1) begin n_fail++; $display("FAIL after_accept_rsp: got data %0d id %b expected 5 1", bus_if.rsp_data, bus_if.rsp_id); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int seen;
        bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'b1000; bus_if.req0_a = 64'd50; bus_if.req0_b = 64'd5;
        cyc();
        bus_if.req0_valid = 1'b0;
        repeat (2) cyc();
        n_checks++; if (bus_if.alu_op !== 4'b1000) begin n_fail++; $display("FAIL mid_exec_op: got %h expected 8", bus_if.alu_op); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_if.alu_op !== 4'd0 || bus_if.alu_in1 !== 64'd0 || bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got op %h in1 %0d v %b expected 0 0 0", bus_if.alu_op, bus_if.alu_in1, bus_if.rsp_valid); end
        cyc();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (bus_if.rsp_valid !== 1'b0 || bus_if.alu_op !== 4'd0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL no_rsp_after_abort: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_if.rsp_ready = 1'b0;
        clear_reqs();
        test_reset();
        test_add();
        test_contention();
        test_div();
        test_op15();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
